// File: rtl/lv_hv_adc_shadow_bank.sv
// LV-side multi-channel shadow bank for HV ADC samples received over OWT.
// Define LV_HV_SHADOW_STALE_CHK_EN to build per-channel age counters and o_adc_stale.
module lv_hv_adc_shadow_bank #(
  parameter int CH_NUM = 4,
  parameter int ADC_DW = 10,
  parameter int OWT_CMD_BIT_NUM = 8,
  parameter int OWT_ADCD_BIT_NUM = 20,
  parameter logic [OWT_CMD_BIT_NUM-2:0] BASE_ADDR = 7'h1F,
  parameter logic [ADC_DW-1:0] DEFAULT_VAL = '0,
  parameter int STALE_CYC = 16,
  parameter int ERR_CW = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_owt_rx_ack,
  input  logic [OWT_CMD_BIT_NUM-1:0]    i_owt_rx_cmd,
  input  logic [OWT_ADCD_BIT_NUM-1:0]   i_owt_rx_data,
  input  logic                          i_owt_rx_status,
  input  logic                          i_clr,
  output logic [CH_NUM*ADC_DW-1:0]      o_adc_data,
  output logic [CH_NUM-1:0]             o_adc_vld,
  output logic [CH_NUM-1:0]             o_adc_upd,
  output logic [CH_NUM-1:0]             o_adc_stale,
  output logic [ERR_CW-1:0]             o_err_cnt
);

  localparam int PACK = OWT_ADCD_BIT_NUM / ADC_DW;
  localparam int FRM_NUM = (CH_NUM + PACK - 1) / PACK;
  localparam int AW = OWT_CMD_BIT_NUM - 1;

  logic                       wen;
  logic                       frm_ok;
  logic [AW-1:0]              frm_idx;
  logic [CH_NUM-1:0]          wr_ch;

  logic [CH_NUM*ADC_DW-1:0]   data_d, data_q;
  logic [CH_NUM-1:0]          vld_d, vld_q;
  logic [CH_NUM-1:0]          upd_d, upd_q;
  logic [ERR_CW-1:0]          err_d, err_q;

  always_comb begin
    wen     = i_owt_rx_ack & ~i_owt_rx_status
            & i_owt_rx_cmd[OWT_CMD_BIT_NUM-1];
    frm_idx = i_owt_rx_cmd[AW-1:0] - BASE_ADDR;
    frm_ok  = wen && (frm_idx < AW'(FRM_NUM));
    wr_ch   = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      wr_ch[k] = frm_ok && (frm_idx == AW'(k / PACK));
    end
  end

  // Write beats clear per channel; unwritten channels fall back to default.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    upd_d  = '0;
    if (i_clr) begin
      data_d = {CH_NUM{DEFAULT_VAL}};
      vld_d  = '0;
    end
    for (int k = 0; k < CH_NUM; k++) begin
      if (wr_ch[k]) begin
        data_d[k*ADC_DW +: ADC_DW] =
          i_owt_rx_data[(k % PACK)*ADC_DW +: ADC_DW];
        vld_d[k] = 1'b1;
        upd_d[k] = 1'b1;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (i_clr) begin
      err_d = '0;
    end else if (i_owt_rx_ack && i_owt_rx_status && !(&err_q)) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q <= {CH_NUM{DEFAULT_VAL}};
      vld_q  <= '0;
      upd_q  <= '0;
      err_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      upd_q  <= upd_d;
      err_q  <= err_d;
    end
  end

`ifdef LV_HV_SHADOW_STALE_CHK_EN
  localparam int AGE_W = $clog2(STALE_CYC + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STALE_CYC);

  logic [CH_NUM-1:0][AGE_W-1:0] age_d, age_q;
  logic [CH_NUM-1:0]            stale_d, stale_q;

  always_comb begin
    age_d   = age_q;
    stale_d = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (wr_ch[k] || i_clr || !vld_q[k]) begin
        age_d[k] = '0;
      end else if (age_q[k] != AGE_MAX) begin
        age_d[k] = age_q[k] + 1'b1;
      end
      stale_d[k] = vld_d[k] && (age_d[k] == AGE_MAX);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      age_q   <= '0;
      stale_q <= '0;
    end else begin
      age_q   <= age_d;
      stale_q <= stale_d;
    end
  end

  assign o_adc_stale = stale_q;
`else
  assign o_adc_stale = '0;
`endif

  assign o_adc_data = data_q;
  assign o_adc_vld  = vld_q;
  assign o_adc_upd  = upd_q;
  assign o_err_cnt  = err_q;

endmodule

// File: tb/tb_lv_hv_adc_shadow_bank.sv
// Self-checking bench for lv_hv_adc_shadow_bank: vector table, corner sequences
// and randomized frames against a channel-level reference model.
module tb_lv_hv_adc_shadow_bank;

  localparam int CH = 4;
  localparam int ADW = 10;
  localparam int PACK = 2;
  localparam int FRM = 2;
  localparam int BASE = 'h1F;
  localparam int STALE = 16;
`ifdef LV_HV_SHADOW_STALE_CHK_EN
  localparam bit STALE_EN = 1'b1;
`else
  localparam bit STALE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ack = 1'b0;
  logic [7:0]  cmd = '0;
  logic [19:0] dat = '0;
  logic        st  = 1'b0;
  logic        clr = 1'b0;
  logic [39:0] o_data;
  logic [3:0]  o_vld, o_upd, o_stale;
  logic [7:0]  o_err;

  int n_chk = 0;
  int n_err = 0;

  logic [9:0] m_data [CH];
  bit         m_vld  [CH];
  bit         m_upd  [CH];
  int         m_since[CH];
  int         m_err;

  always #5 clk = ~clk;

  lv_hv_adc_shadow_bank #(
    .CH_NUM(4), .ADC_DW(10), .OWT_CMD_BIT_NUM(8),
    .OWT_ADCD_BIT_NUM(20), .BASE_ADDR(7'h1F),
    .DEFAULT_VAL(10'h0), .STALE_CYC(16), .ERR_CW(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_owt_rx_ack(ack),
    .i_owt_rx_cmd(cmd), .i_owt_rx_data(dat),
    .i_owt_rx_status(st), .i_clr(clr),
    .o_adc_data(o_data), .o_adc_vld(o_vld), .o_adc_upd(o_upd),
    .o_adc_stale(o_stale), .o_err_cnt(o_err)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_data[k] = '0;
      m_vld[k] = 0;
      m_upd[k] = 0;
      m_since[k] = 0;
    end
    m_err = 0;
  endtask

  task automatic model_step(bit a, logic [7:0] c, logic [19:0] d,
                            bit s, bit cl);
    int f;
    int chn;
    if (cl) m_err = 0;
    else if (a && s && m_err < 255) m_err++;
    for (int k = 0; k < CH; k++) begin
      m_upd[k] = 0;
      if (cl) begin
        m_vld[k] = 0;
        m_data[k] = '0;
        m_since[k] = 0;
      end else if (m_vld[k]) begin
        m_since[k]++;
      end
    end
    if (a && !s && c[7]) begin
      f = int'(c[6:0]) - BASE;
      if (f >= 0 && f < FRM) begin
        for (int j = 0; j < PACK; j++) begin
          chn = f * PACK + j;
          if (chn < CH) begin
            m_data[chn] = d[j*ADW +: ADW];
            m_vld[chn] = 1;
            m_upd[chn] = 1;
            m_since[chn] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_model(string tag);
    logic [39:0] ed;
    logic [3:0]  ev, eu, es;
    for (int k = 0; k < CH; k++) begin
      ed[k*ADW +: ADW] = m_data[k];
      ev[k] = m_vld[k];
      eu[k] = m_upd[k];
      es[k] = STALE_EN && m_vld[k] && (m_since[k] >= STALE);
    end
    chk({tag, ".data"}, 64'(o_data), 64'(ed));
    chk({tag, ".vld"}, 64'(o_vld), 64'(ev));
    chk({tag, ".upd"}, 64'(o_upd), 64'(eu));
    chk({tag, ".stale"}, 64'(o_stale), 64'(es));
    chk({tag, ".err"}, 64'(o_err), 64'(m_err));
  endtask

  task automatic cycle(bit a, logic [7:0] c, logic [19:0] d,
                       bit s, bit cl);
    @(negedge clk);
    ack = a; cmd = c; dat = d; st = s; clr = cl;
    @(posedge clk);
    model_step(a, c, d, s, cl);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 20'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ack = 0; clr = 0; st = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  typedef struct {
    logic        a;
    logic [7:0]  c;
    logic [19:0] d;
    logic        s;
    logic        cl;
    logic [39:0] e_data;
    logic [3:0]  e_vld;
    logic [3:0]  e_upd;
    logic [7:0]  e_err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [39:0] d1, d2, d3;
    logic [7:0]  rc;
    d1 = {10'h000, 10'h000, 10'h155, 10'h0AA};
    d2 = {10'h000, 10'h3FF, 10'h155, 10'h0AA};
    d3 = {10'h000, 10'h3FF, 10'h000, 10'h3FF};
    tbl[0] = '{1'b1, 8'h9F, 20'h554AA, 1'b0, 1'b0, d1, 4'b0011, 4'b0011, 8'd0};
    tbl[1] = '{1'b0, 8'h00, 20'h00000, 1'b0, 1'b0, d1, 4'b0011, 4'b0000, 8'd0};
    tbl[2] = '{1'b1, 8'hA0, 20'h003FF, 1'b0, 1'b0, d2, 4'b1111, 4'b1100, 8'd0};
    tbl[3] = '{1'b1, 8'hA1, 20'h12345, 1'b0, 1'b0, d2, 4'b1111, 4'b0000, 8'd0};
    tbl[4] = '{1'b1, 8'h9F, 20'hFFFFF, 1'b1, 1'b0, d2, 4'b1111, 4'b0000, 8'd1};
    tbl[5] = '{1'b1, 8'h1F, 20'h00000, 1'b0, 1'b0, d2, 4'b1111, 4'b0000, 8'd1};
    tbl[6] = '{1'b1, 8'h9E, 20'hFFFFF, 1'b0, 1'b0, d2, 4'b1111, 4'b0000, 8'd1};
    tbl[7] = '{1'b1, 8'h9F, 20'h003FF, 1'b0, 1'b0, d3, 4'b1111, 4'b0011, 8'd1};
    tbl[8] = '{1'b1, 8'h9F, 20'h003FF, 1'b0, 1'b0, d3, 4'b1111, 4'b0011, 8'd1};
    tbl[9] = '{1'b0, 8'h00, 20'h00000, 1'b0, 1'b0, d3, 4'b1111, 4'b0000, 8'd1};

    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst.data", 64'(o_data), 64'h0);
    chk("rst.vld", 64'(o_vld), 64'h0);
    chk("rst.upd", 64'(o_upd), 64'h0);
    chk("rst.stale", 64'(o_stale), 64'h0);
    chk("rst.err", 64'(o_err), 64'h0);
    rst = 0;

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].a, tbl[i].c, tbl[i].d, tbl[i].s, tbl[i].cl);
      chk($sformatf("tbl%0d.data", i), 64'(o_data), 64'(tbl[i].e_data));
      chk($sformatf("tbl%0d.vld", i), 64'(o_vld), 64'(tbl[i].e_vld));
      chk($sformatf("tbl%0d.upd", i), 64'(o_upd), 64'(tbl[i].e_upd));
      chk($sformatf("tbl%0d.err", i), 64'(o_err), 64'(tbl[i].e_err));
      chk($sformatf("tbl%0d.stale", i), 64'(o_stale), 64'h0);
    end

    // staleness
    do_reset();
    cycle(1'b1, 8'h9F, 20'h12345, 1'b0, 1'b0);
    check_model("stl.wr");
    for (int i = 0; i < 15; i++) idle();
    chk("stl.pre", 64'(o_stale), 64'h0);
    idle();
    chk("stl.hit", 64'(o_stale), STALE_EN ? 64'h3 : 64'h0);
    check_model("stl.hit");
    cycle(1'b1, 8'h9F, 20'h54321, 1'b0, 1'b0);
    chk("stl.rewr", 64'(o_stale), 64'h0);
    check_model("stl.rewr");

    // error saturation
    for (int i = 0; i < 300; i++) begin
      rc = 8'($urandom);
      cycle(1'b1, rc, 20'($urandom), 1'b1, 1'b0);
    end
    chk("sat.err", 64'(o_err), 64'hFF);
    check_model("sat");

    // clear with same-cycle write
    cycle(1'b1, 8'hA0, 20'h2A1B3, 1'b0, 1'b1);
    chk("clrw.vld", 64'(o_vld), 64'hC);
    chk("clrw.lo", 64'(o_data[19:0]), 64'h0);
    chk("clrw.ch2", 64'(o_data[29:20]), 64'h1B3);
    chk("clrw.ch3", 64'(o_data[39:30]), 64'h0A8);
    chk("clrw.err", 64'(o_err), 64'h0);
    check_model("clrw");

    // clear beats a same-cycle error frame
    cycle(1'b1, 8'h9F, 20'h0, 1'b1, 1'b0);
    cycle(1'b1, 8'h9F, 20'h0, 1'b1, 1'b0);
    chk("clre.pre", 64'(o_err), 64'h2);
    cycle(1'b1, 8'h9F, 20'h0, 1'b1, 1'b1);
    chk("clre.err", 64'(o_err), 64'h0);
    chk("clre.vld", 64'(o_vld), 64'h0);

    // asynchronous reset during an in-flight frame
    cycle(1'b1, 8'h9F, 20'h0, 1'b1, 1'b0);
    cycle(1'b1, 8'h9F, 20'hABCDE, 1'b0, 1'b0);
    check_model("arst.pre");
    @(negedge clk);
    ack = 1; cmd = 8'hA0; dat = 20'hFFFFF; st = 0; clr = 0;
    #2 rst = 1;
    #1;
    chk("arst.data", 64'(o_data), 64'h0);
    chk("arst.vld", 64'(o_vld), 64'h0);
    chk("arst.upd", 64'(o_upd), 64'h0);
    chk("arst.stale", 64'(o_stale), 64'h0);
    chk("arst.err", 64'(o_err), 64'h0);
    @(negedge clk);
    ack = 0;
    rst = 0;
    model_reset();
    idle();
    check_model("arst.post");

    // randomized frames against the model
    for (int i = 0; i < 600; i++) begin
      bit          a, s, cl;
      logic [6:0]  ad;
      a = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 7) == 0);
      cl = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 4))
        0: ad = 7'h1E;
        1: ad = 7'h1F;
        2: ad = 7'h20;
        3: ad = 7'h21;
        default: ad = 7'($urandom);
      endcase
      cycle(a, {($urandom_range(0, 3) != 0), ad}, 20'($urandom), s, cl);
      check_model("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
